serial_char_rx: RTL and testbench

Upstream front end for the character-stream pattern detectors. Deserializes an asynchronous, UART-style serial line (start bit, 8 data bits LSB first, 1 stop bit) into 8-bit characters. Each completed character is presented on `char` with a one-cycle `char_valid` strobe, which downstream detectors use as their advance enable. Framing errors are flagged and the frame is discarded.

---
 rtl/serial_char_rx.sv | 118 +++++++++++
 tb/tb_serial_char_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_char_rx.sv
// UART-style character receiver: 1 start, 8 data (LSB first), 1 stop.
// Good frames update char with a one-cycle char_valid; bad stop bits raise frame_err.
module serial_char_rx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] char,
   output logic       char_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   logic [7:0]      shreg;
   logic            rx_meta;
   logic            rx_s;

   // Two-flop synchronizer; resets to the idle-high line level so no false start appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM; busy is registered alongside the state so it tracks "not IDLE" exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         char       <= '0;
         char_valid <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         char_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_TC) begin
                  cnt <= '0;
                  idx <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == FULL_TC) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[7:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == FULL_TC) begin
                  cnt <= '0;
                  if (rx_s) begin
                     char       <= shreg;
                     char_valid <= 1'b1;
                     state      <= IDLE;
                     busy       <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            // A line stuck low must go high again before another start can be recognised.
            BREAK: begin
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_char_rx.sv
// Directed bench for serial_char_rx: N=4 main instance plus N=2 and N=16 instances.
// Monitors log each pulse with its latency from the busy rise (edge D).
module tb_serial_char_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd4, rxd2, rxd16;
   logic [7:0] char4, char2, char16;
   logic       valid4, valid2, valid16;
   logic       ferr4, ferr2, ferr16;
   logic       busy4, busy2, busy16;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_char_rx #(.CLKS_PER_BIT(4)) dut (
      .clk(clk), .reset(reset), .rxd(rxd4), .char(char4),
      .char_valid(valid4), .frame_err(ferr4), .busy(busy4));
   serial_char_rx #(.CLKS_PER_BIT(2)) dut2 (
      .clk(clk), .reset(reset), .rxd(rxd2), .char(char2),
      .char_valid(valid2), .frame_err(ferr2), .busy(busy2));
   serial_char_rx #(.CLKS_PER_BIT(16)) dut16 (
      .clk(clk), .reset(reset), .rxd(rxd16), .char(char16),
      .char_valid(valid16), .frame_err(ferr16), .busy(busy16));

   logic [7:0] charQ4[$], charQ2[$], charQ16[$];
   int         latQ4[$], latQ2[$], latQ16[$];
   int         dStart4 = 0, dStart2 = 0, dStart16 = 0;
   logic       busyPrev4 = 1'b0, busyPrev2 = 1'b0, busyPrev16 = 1'b0;
   int         busyFalls4 = 0, busyFallCyc4 = 0, busyHigh4 = 0;
   int         ferrCount4 = 0, ferrLat4 = 0, ferrOther = 0;
   int         fallCyc = 0;

   // Sampling on the falling edge keeps the monitors clear of the active edge.
   always @(negedge clk) begin
      if (busy4 && !busyPrev4) dStart4 = cyc;
      if (!busy4 && busyPrev4) begin
         busyFalls4++;
         busyFallCyc4 = cyc;
      end
      if (busy4) busyHigh4++;
      if (valid4) begin
         charQ4.push_back(char4);
         latQ4.push_back(cyc - dStart4);
      end
      if (ferr4) begin
         ferrCount4++;
         ferrLat4 = cyc - dStart4;
      end
      busyPrev4 = busy4;
   end

   always @(negedge clk) begin
      if (busy2 && !busyPrev2) dStart2 = cyc;
      if (busy16 && !busyPrev16) dStart16 = cyc;
      if (valid2) begin
         charQ2.push_back(char2);
         latQ2.push_back(cyc - dStart2);
      end
      if (valid16) begin
         charQ16.push_back(char16);
         latQ16.push_back(cyc - dStart16);
      end
      if (ferr2 || ferr16) ferrOther++;
      busyPrev2  = busy2;
      busyPrev16 = busy16;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] byteAt(input logic [7:0] q[$], input int i);
      return (i < q.size()) ? {24'h0, q[i]} : 32'hDEAD;
   endfunction

   function automatic logic [31:0] intAt(input int q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setLine(input int which, input logic v);
      case (which)
         2:       rxd2  = v;
         16:      rxd16 = v;
         default: rxd4  = v;
      endcase
   endtask

   task automatic applyStimulus(input int n, input logic [7:0] data, input logic stopBit);
      fallCyc = cyc;
      setLine(n, 1'b0);
      step(n);
      for (int i = 0; i < 8; i++) begin
         setLine(n, data[i]);
         step(n);
      end
      setLine(n, stopBit);
      step(n);
   endtask

   task automatic clearLogs;
      charQ4.delete(); latQ4.delete();
      charQ2.delete(); latQ2.delete();
      charQ16.delete(); latQ16.delete();
      ferrCount4 = 0;
      busyFalls4 = 0;
   endtask

   logic [7:0] stream[6] = '{8'h63, 8'h73, 8'h63, 8'h6F, 8'h72, 8'h65};
   int lag;
   int riseCyc;
   int busyBase;

   initial begin
      reset = 1'b1;
      rxd4 = 1'b1; rxd2 = 1'b1; rxd16 = 1'b1;
      step(3);
      checkOutput("rst_char", char4, 8'h00);
      checkOutput("rst_valid", valid4, 1'b0);
      checkOutput("rst_ferr", ferr4, 1'b0);
      checkOutput("rst_busy", busy4, 1'b0);
      reset = 1'b0;
      step(5);

      // Single character
      clearLogs();
      applyStimulus(4, 8'h63, 1'b1);
      lag = dStart4 - fallCyc;
      step(10);
      checkOutput("s1_count", charQ4.size(), 1);
      checkOutput("s1_char", byteAt(charQ4, 0), 8'h63);
      checkOutput("s1_lat", intAt(latQ4, 0), 38);
      checkOutput("s1_ferr", ferrCount4, 0);
      checkOutput("s1_hold", char4, 8'h63);
      checkOutput("s1_dlag", (lag >= 2 && lag <= 3), 1'b1);

      // False start: one low cycle
      clearLogs();
      busyBase = busyHigh4;
      setLine(4, 1'b0);
      step(1);
      setLine(4, 1'b1);
      step(10);
      checkOutput("s3_busycyc", busyHigh4 - busyBase, 2);
      checkOutput("s3_idle_at", busyFallCyc4 - dStart4, 2);
      checkOutput("s3_valid", charQ4.size(), 0);
      checkOutput("s3_ferr", ferrCount4, 0);

      // Framing error followed by a held-low line
      clearLogs();
      applyStimulus(4, 8'hA5, 1'b0);
      step(20);
      setLine(4, 1'b1);
      riseCyc = cyc;
      step(10);
      checkOutput("s4_ferr", ferrCount4, 1);
      checkOutput("s4_ferrlat", ferrLat4, 38);
      checkOutput("s4_valid", charQ4.size(), 0);
      checkOutput("s4_char", char4, 8'h63);
      checkOutput("s4_busyfalls", busyFalls4, 1);
      checkOutput("s4_busyfall", busyFallCyc4 - riseCyc, 3);
      clearLogs();
      applyStimulus(4, 8'h41, 1'b1);
      step(10);
      checkOutput("s4_next_count", charQ4.size(), 1);
      checkOutput("s4_next_char", byteAt(charQ4, 0), 8'h41);

      // Back-to-back stream at full line rate
      clearLogs();
      for (int i = 0; i < 6; i++) applyStimulus(4, stream[i], 1'b1);
      step(10);
      checkOutput("s2_count", charQ4.size(), 6);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("s2_char%0d", i), byteAt(charQ4, i), {24'h0, stream[i]});
         checkOutput($sformatf("s2_lat%0d", i), intAt(latQ4, i), 38);
      end
      checkOutput("s2_ferr", ferrCount4, 0);

      // Reset during data bit 3 of 8'hFF
      clearLogs();
      setLine(4, 1'b0);
      step(4);
      setLine(4, 1'b1);
      step(14);
      checkOutput("s5_busy_pre", busy4, 1'b1);
      reset = 1'b1;
      #1;
      checkOutput("s5_char", char4, 8'h00);
      checkOutput("s5_valid", valid4, 1'b0);
      checkOutput("s5_ferr", ferr4, 1'b0);
      checkOutput("s5_busy", busy4, 1'b0);
      step(3);
      reset = 1'b0;
      step(40);
      checkOutput("s5_nopulse", charQ4.size(), 0);
      checkOutput("s5_noferr", ferrCount4, 0);
      applyStimulus(4, 8'h00, 1'b1);
      step(10);
      checkOutput("s5_count", charQ4.size(), 1);
      checkOutput("s5_rxchar", byteAt(charQ4, 0), 8'h00);
      checkOutput("s5_lat", intAt(latQ4, 0), 38);

      // Parameter sweep
      clearLogs();
      applyStimulus(2, 8'h80, 1'b1);
      applyStimulus(2, 8'h01, 1'b1);
      step(10);
      checkOutput("n2_count", charQ2.size(), 2);
      checkOutput("n2_char0", byteAt(charQ2, 0), 8'h80);
      checkOutput("n2_char1", byteAt(charQ2, 1), 8'h01);
      checkOutput("n2_lat0", intAt(latQ2, 0), 19);
      checkOutput("n2_lat1", intAt(latQ2, 1), 19);
      applyStimulus(16, 8'h80, 1'b1);
      applyStimulus(16, 8'h01, 1'b1);
      step(20);
      checkOutput("n16_count", charQ16.size(), 2);
      checkOutput("n16_char0", byteAt(charQ16, 0), 8'h80);
      checkOutput("n16_char1", byteAt(charQ16, 1), 8'h01);
      checkOutput("n16_lat0", intAt(latQ16, 0), 152);
      checkOutput("n16_lat1", intAt(latQ16, 1), 152);
      checkOutput("sweep_ferr", ferrOther, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
